// File: rtl/jtframe_dwnld_wrq_if.sv
// SDRAM programming port: one word write held until the controller acknowledges it.
`timescale 1ns/1ps
interface jtframe_dwnld_wrq_if;
    logic        prog_we;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic        prog_ack;

    modport master (output prog_we, prog_addr, prog_data, prog_mask, input prog_ack);
    modport slave  (input prog_we, prog_addr, prog_data, prog_mask, output prog_ack);
endinterface

// File: rtl/jtframe_dwnld_wrq.sv
// Download byte stream -> 16-bit word FIFO -> SDRAM we/ack writes; JTFRAME_WRQ_MERGE_EN packs byte pairs.
// Push-to-prog_we 2 cycles, one low gap per write; in_full at one free entry, extra pushes drop and set ovf.
`timescale 1ns/1ps
module jtframe_dwnld_wrq #(
    parameter int DEPTH_LOG2   = 3,
    parameter int FLUSH_CYCLES = 16,
    parameter bit SWAB         = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  downloading,
    input  logic                  in_we,
    input  logic [22:0]           in_addr,
    input  logic [7:0]            in_data,
    output logic                  in_full,
    output logic                  ovf,
    output logic                  dwnld_busy,
    jtframe_dwnld_wrq_if.master   prog
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int IW    = $clog2(FLUSH_CYCLES + 1);

    typedef struct packed {
        logic [21:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_t;

    logic       lane;
    logic [1:0] lane_bit;
    logic       dl_q, dl_rise;
    logic       push_vld, push_ok, pop, pack_busy;
    entry_t     push_dat;

    assign lane     = in_addr[0] ^ SWAB;
    assign lane_bit = lane ? 2'b10 : 2'b01;
    assign dl_rise  = downloading & ~dl_q;

`ifdef JTFRAME_WRQ_MERGE_EN
    entry_t         pack;
    logic           pack_vld, merge_hit, dl_fall, flush;
    logic [IW-1:0]  idle_cnt;
    logic [15:0]    merged;
    logic [1:0]     merged_mask;

    always_comb begin
        merge_hit   = pack_vld && (pack.addr == in_addr[22:1]) && ((pack.mask & lane_bit) != 2'b00);
        dl_fall     = dl_q & ~downloading;
        flush       = pack_vld && !in_we && !dl_rise &&
                      (dl_fall || idle_cnt >= IW'(FLUSH_CYCLES - 1));
        merged      = lane ? {in_data, pack.data[7:0]} : {pack.data[15:8], in_data};
        merged_mask = pack.mask & ~lane_bit;
        push_vld    = 1'b0;
        push_dat    = pack;
        if (in_we) begin
            if (merge_hit) begin
                push_vld = (merged_mask == 2'b00);
                push_dat = '{addr: pack.addr, data: merged, mask: 2'b00};
            end else begin
                push_vld = pack_vld;
            end
        end else begin
            push_vld = flush;
        end
    end

    // A stale pack left over from a previous window is discarded on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_vld <= 1'b0;
            pack     <= '{addr: '0, data: '0, mask: 2'b11};
            idle_cnt <= '0;
        end else if (in_we) begin
            idle_cnt <= '0;
            if (merge_hit) begin
                pack.data <= merged;
                pack.mask <= merged_mask;
                if (merged_mask == 2'b00) pack_vld <= 1'b0;
            end else begin
                pack_vld <= 1'b1;
                pack     <= '{addr: in_addr[22:1], data: {in_data, in_data}, mask: ~lane_bit};
            end
        end else begin
            if (dl_rise)                          idle_cnt <= '0;
            else if (idle_cnt != IW'(FLUSH_CYCLES)) idle_cnt <= idle_cnt + IW'(1);
            if (flush || dl_rise) pack_vld <= 1'b0;
        end
    end

    assign pack_busy = pack_vld;
`else
    always_comb begin
        push_vld = in_we;
        push_dat = '{addr: in_addr[22:1], data: {in_data, in_data}, mask: ~lane_bit};
    end

    assign pack_busy = 1'b0;
`endif

    entry_t                mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    state_t                state, state_nxt;
    logic                  we_q;
    entry_t                head_q;

    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign push_ok = push_vld && ((count != (DEPTH_LOG2+1)'(DEPTH)) || pop);
    assign in_full = count >= (DEPTH_LOG2+1)'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            dl_q   <= 1'b0;
        end else begin
            dl_q <= downloading;
            if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)     rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
                default: count <= count;
            endcase
            if (dl_rise)                    ovf <= 1'b0;
            else if (push_vld && !push_ok)  ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE: if (count != '0) begin
                pop       = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: if (prog.prog_ack) state_nxt = ST_GAP;
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            head_q <= '{addr: '0, data: '0, mask: 2'b11};
        end else if (pop) begin
            we_q   <= 1'b1;
            head_q <= mem[rd_ptr];
        end else if (state == ST_WAIT && prog.prog_ack) begin
            we_q   <= 1'b0;
        end
    end

    assign prog.prog_we   = we_q;
    assign prog.prog_addr = head_q.addr;
    assign prog.prog_data = head_q.data;
    assign prog.prog_mask = head_q.mask;

    assign dwnld_busy = downloading | pack_busy | (count != '0) | (state != ST_IDLE);
endmodule
